// File: rtl/frame_demux_if.sv
// frame_demux_if: ingress/egress word-stream bundle for frame_demux_1ton
//    in_data/in_valid/in_ready/in_sel : ingress word, handshake and egress mask
//    out_data/out_valid/out_ready     : shared egress word, per-port valid/ready
//    master: source/sink side, slave: demux side
interface frame_demux_if #(
   parameter int W = 9,
   parameter int N = 4
);
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_sel;
   logic [W-1:0] out_data;
   logic [N-1:0] out_valid;
   logic [N-1:0] out_ready;
   modport master (output in_data, in_valid, in_sel, out_ready,
                   input  in_ready, out_data, out_valid);
   modport slave  (input  in_data, in_valid, in_sel, out_ready,
                   output in_ready, out_data, out_valid);
endinterface

// File: rtl/frame_demux_1ton.sv
// frame_demux_1ton: routes whole frames from one word stream to a subset of N ports
//    clk, rst_n  : clock, synchronous active-low reset
//    bus (slave) : ingress word/valid/ready/sel, egress word/valid[N]/ready[N]
//    drop_cnt    : saturating count of frames dropped for an all-zero mask
//    port_frames : per-port saturating delivered-frame counters
//                  (present only with FRAME_DEMUX_PORT_STATS_EN defined)
module frame_demux_1ton #(
   parameter int W     = 9,
   parameter int N     = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   frame_demux_if.slave     bus,
   output logic [CNT_W-1:0] drop_cnt
`ifdef FRAME_DEMUX_PORT_STATS_EN
   ,
   output logic [N*CNT_W-1:0] port_frames
`endif
);
   typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;
   state_t       state, state_nxt;
   logic [N-1:0] mask, stage_mask, load_mask;
   logic [W-1:0] stage_data;
   logic         stage_valid, fire, accept, eof, rdy, load, drop_inc;
   assign eof           = bus.in_data[W-1];
   assign fire          = stage_valid & ((bus.out_ready & stage_mask) == stage_mask);
   assign accept        = bus.in_valid & rdy;
   assign bus.in_ready  = rdy;
   assign bus.out_data  = stage_data;
   assign bus.out_valid = stage_valid ? stage_mask : '0;
   always_comb begin
      state_nxt = state;
      rdy       = !stage_valid | fire;
      load      = 1'b0;
      drop_inc  = 1'b0;
      load_mask = mask;
      case (state)
         IDLE: begin
            // a frame that is about to be dropped never needs the stage
            rdy       = (bus.in_sel == '0) | !stage_valid | fire;
            load_mask = bus.in_sel;
            if (accept) begin
               load      = bus.in_sel != '0;
               drop_inc  = bus.in_sel == '0;
               state_nxt = eof ? IDLE : (bus.in_sel != '0 ? FWD : DROP);
            end
         end
         FWD: begin
            load      = accept;
            state_nxt = (accept && eof) ? IDLE : FWD;
         end
         DROP: begin
            rdy       = 1'b1;
            state_nxt = (accept && eof) ? IDLE : DROP;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         mask        <= '0;
         stage_valid <= 1'b0;
         stage_mask  <= '0;
         stage_data  <= '0;
         drop_cnt    <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && accept) mask <= bus.in_sel;
         // reload wins over fire so back-to-back words see no bubble
         if (load) begin
            stage_valid <= 1'b1;
            stage_mask  <= load_mask;
            stage_data  <= bus.in_data;
         end else if (fire) begin
            stage_valid <= 1'b0;
         end
         if (drop_inc && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end
`ifdef FRAME_DEMUX_PORT_STATS_EN
   for (genvar i = 0; i < N; i++) begin : g_stat
      always_ff @(posedge clk) begin
         if (!rst_n)
            port_frames[CNT_W*i +: CNT_W] <= '0;
         else if (fire && stage_data[W-1] && stage_mask[i] && !(&port_frames[CNT_W*i +: CNT_W]))
            port_frames[CNT_W*i +: CNT_W] <= port_frames[CNT_W*i +: CNT_W] + CNT_W'(1);
      end
   end
`endif
endmodule

// File: tb/tb_frame_demux_1ton.sv
// tb_frame_demux_1ton: directed checks of frame_demux_1ton (N=4, W=9)
module tb_frame_demux_1ton;
   localparam int W = 9, N = 4, CNT_W = 16;
   logic clk = 1'b0;
   logic rst_n;
   logic [CNT_W-1:0] drop_cnt;
   int tests = 0, fails = 0;
   frame_demux_if #(.W(W), .N(N)) bus ();
`ifdef FRAME_DEMUX_PORT_STATS_EN
   logic [N*CNT_W-1:0] port_frames;
`endif
   frame_demux_1ton #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave),
      .drop_cnt(drop_cnt)
`ifdef FRAME_DEMUX_PORT_STATS_EN
      ,
      .port_frames(port_frames)
`endif
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [W-1:0] d, input logic [N-1:0] s);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_sel   = s;
      #1;
   endtask
   task automatic out_is(input string tag, input logic [N-1:0] v, input logic [W-1:0] d);
      check({tag, "_valid"}, 64'(bus.out_valid), 64'(v));
      if (v != '0) check({tag, "_data"}, 64'(bus.out_data), 64'(d));
   endtask
   initial begin
      rst_n = 1'b0;
      bus.out_ready = '0;
      drive(1'b0, '0, '0);
      tick;
      tick;
      check("rst_out_valid", 64'(bus.out_valid), 64'h0);
      check("rst_out_data", 64'(bus.out_data), 64'h0);
      check("rst_drop_cnt", 64'(drop_cnt), 64'h0);
      rst_n = 1'b1;
      // unicast to port 1
      bus.out_ready = 4'hF;
      drive(1'b1, 9'h0A1, 4'b0010);
      check("uni_rdy1", 64'(bus.in_ready), 64'h1);
      tick;
      out_is("uni_w1", 4'b0010, 9'h0A1);
      drive(1'b1, 9'h0A2, 4'b0010);
      check("uni_rdy2", 64'(bus.in_ready), 64'h1);
      tick;
      out_is("uni_w2", 4'b0010, 9'h0A2);
      drive(1'b1, 9'h1A3, 4'b0010);
      check("uni_rdy3", 64'(bus.in_ready), 64'h1);
      tick;
      out_is("uni_w3", 4'b0010, 9'h1A3);
      drive(1'b0, '0, '0);
      tick;
      out_is("uni_empty", 4'b0000, '0);
      check("uni_drop_cnt", 64'(drop_cnt), 64'h0);
      // multicast with backpressure from port 2
      bus.out_ready = 4'b0001;
      drive(1'b1, 9'h055, 4'b0101);
      tick;
      out_is("mc_load", 4'b0101, 9'h055);
      drive(1'b1, 9'h156, 4'b0101);
      for (int k = 0; k < 3; k++) begin
         check("mc_stall_rdy", 64'(bus.in_ready), 64'h0);
         tick;
         out_is("mc_hold", 4'b0101, 9'h055);
      end
      bus.out_ready = 4'b0101;
      #1;
      check("mc_fire_rdy", 64'(bus.in_ready), 64'h1);
      tick;
      out_is("mc_w2", 4'b0101, 9'h156);
      drive(1'b0, '0, '0);
      tick;
      out_is("mc_empty", 4'b0000, '0);
      // dropped frame, then forward to port 3
      bus.out_ready = 4'hF;
      drive(1'b1, 9'h011, 4'b0000);
      check("drop_rdy1", 64'(bus.in_ready), 64'h1);
      tick;
      out_is("drop_w1", 4'b0000, '0);
      drive(1'b1, 9'h012, 4'b1111);
      check("drop_rdy2", 64'(bus.in_ready), 64'h1);
      tick;
      out_is("drop_w2", 4'b0000, '0);
      drive(1'b1, 9'h013, 4'b0000);
      check("drop_rdy3", 64'(bus.in_ready), 64'h1);
      tick;
      out_is("drop_w3", 4'b0000, '0);
      drive(1'b1, 9'h114, 4'b0000);
      check("drop_rdy4", 64'(bus.in_ready), 64'h1);
      tick;
      out_is("drop_w4", 4'b0000, '0);
      check("drop_cnt1", 64'(drop_cnt), 64'h1);
      drive(1'b1, 9'h1AA, 4'b1000);
      tick;
      out_is("drop_next", 4'b1000, 9'h1AA);
      check("drop_cnt_hold", 64'(drop_cnt), 64'h1);
      drive(1'b0, '0, '0);
      tick;
      // mask is latched on the first word only
      drive(1'b1, 9'h021, 4'b0001);
      tick;
      out_is("latch_w1", 4'b0001, 9'h021);
      drive(1'b1, 9'h022, 4'b1110);
      tick;
      out_is("latch_w2", 4'b0001, 9'h022);
      drive(1'b1, 9'h123, 4'b1110);
      tick;
      out_is("latch_w3", 4'b0001, 9'h123);
      drive(1'b0, '0, '0);
      tick;
      // reset in the middle of a frame
      drive(1'b1, 9'h031, 4'b0010);
      tick;
      drive(1'b1, 9'h032, 4'b0010);
      tick;
      out_is("mid_w2", 4'b0010, 9'h032);
      drive(1'b0, '0, '0);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      check("mid_rst_valid", 64'(bus.out_valid), 64'h0);
      check("mid_rst_drop", 64'(drop_cnt), 64'h0);
      drive(1'b1, 9'h041, 4'b0100);
      check("mid_rdy_after_rst", 64'(bus.in_ready), 64'h1);
      tick;
      out_is("mid_new_w1", 4'b0100, 9'h041);
      drive(1'b1, 9'h142, 4'b0000);
      tick;
      out_is("mid_new_w2", 4'b0100, 9'h142);
      check("mid_no_drop", 64'(drop_cnt), 64'h0);
      // back-to-back single-word frames
      drive(1'b1, 9'h101, 4'b0001);
      tick;
      out_is("b2b_1", 4'b0001, 9'h101);
      drive(1'b1, 9'h102, 4'b0010);
      tick;
      out_is("b2b_2", 4'b0010, 9'h102);
      drive(1'b1, 9'h103, 4'b0000);
      check("b2b_drop_rdy", 64'(bus.in_ready), 64'h1);
      tick;
      out_is("b2b_3", 4'b0000, '0);
      check("b2b_drop_cnt", 64'(drop_cnt), 64'h1);
      drive(1'b0, '0, '0);
      tick;
`ifdef FRAME_DEMUX_PORT_STATS_EN
      check("stat_p0", 64'(port_frames[0 +: CNT_W]), 64'h1);
      check("stat_p1", 64'(port_frames[CNT_W +: CNT_W]), 64'h1);
      check("stat_p2", 64'(port_frames[2*CNT_W +: CNT_W]), 64'h1);
      check("stat_p3", 64'(port_frames[3*CNT_W +: CNT_W]), 64'h0);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
